// File: rtl/ex_wb_arbiter_pkg.sv
// Shared constants and helpers for the EX-stage writeback arbiter.
// Payload layout {commit_tag, sysreg, regname, writeback, data, flag, flags_wb, flags_regname}.
package ex_wb_arbiter_pkg;

    localparam int PAYLOAD_W  = 56;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LOCK_THRESH  = 3'd3;
    localparam logic [CNT_W-1:0] STARVE_LIMIT = 3'd4;

    localparam int OFS_FLAGS_REGNAME = 0;
    localparam int OFS_FLAGS_WB      = 4;
    localparam int OFS_FLAG          = 5;
    localparam int OFS_DATA          = 10;
    localparam int OFS_WRITEBACK     = 42;
    localparam int OFS_REGNAME       = 43;
    localparam int OFS_SYSREG        = 49;
    localparam int OFS_COMMIT_TAG    = 50;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_DIV,
        GRANT_FIFO,
        GRANT_BYPASS
    } grant_e;

    // Divider results always write back and never touch the flags register.
    function automatic logic [PAYLOAD_W-1:0] packDivPayload(
        input logic [5:0]  tag,
        input logic        sysreg,
        input logic [5:0]  regname,
        input logic [31:0] data
    );
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        p[OFS_COMMIT_TAG +: 6] = tag;
        p[OFS_SYSREG]          = sysreg;
        p[OFS_REGNAME +: 6]    = regname;
        p[OFS_WRITEBACK]       = 1'b1;
        p[OFS_DATA +: 32]      = data;
        return p;
    endfunction

endpackage

// File: rtl/ex_wb_arbiter_if.sv
// ALU / divider / writeback bundle between the execute units and the arbiter.
interface ex_wb_arbiter_if;
    import ex_wb_arbiter_pkg::*;

    logic                 iALU_VALID;
    logic [PAYLOAD_W-1:0] iALU_PAYLOAD;
    logic                 oALU_LOCK;
    logic                 iDIV_VALID;
    logic [5:0]           iDIV_COMMIT_TAG;
    logic                 iDIV_SYSREG;
    logic [5:0]           iDIV_REGNAME;
    logic [31:0]          iDIV_DATA;
    logic                 oDIV_BUSY;
    logic                 oWB_VALID;
    logic [PAYLOAD_W-1:0] oWB_PAYLOAD;
    logic                 oERR_OVERFLOW;

    modport master (
        output iALU_VALID, iALU_PAYLOAD, iDIV_VALID, iDIV_COMMIT_TAG,
               iDIV_SYSREG, iDIV_REGNAME, iDIV_DATA,
        input  oALU_LOCK, oDIV_BUSY, oWB_VALID, oWB_PAYLOAD, oERR_OVERFLOW
    );

    modport slave (
        input  iALU_VALID, iALU_PAYLOAD, iDIV_VALID, iDIV_COMMIT_TAG,
               iDIV_SYSREG, iDIV_REGNAME, iDIV_DATA,
        output oALU_LOCK, oDIV_BUSY, oWB_VALID, oWB_PAYLOAD, oERR_OVERFLOW
    );
endinterface

// File: rtl/ex_wb_skid_fifo.sv
// 4-entry in-order buffer for ALU results waiting on the writeback port.
module ex_wb_skid_fifo
    import ex_wb_arbiter_pkg::*;
(
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFLUSH,
    input  logic                 iPUSH,
    input  logic                 iPOP,
    input  logic [PAYLOAD_W-1:0] iDATA,
    output logic [PAYLOAD_W-1:0] oDATA,
    output logic [CNT_W-1:0]     oCOUNT
);

    logic [PAYLOAD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_q;
    logic [PTR_W-1:0]     rdPtr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 doPush;
    logic                 doPop;

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign doPop  = iPOP && (count_q != '0);
    assign doPush = iPUSH && ((count_q != FULL_COUNT) || doPop);

    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (iFLUSH) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (doPush && !iFLUSH) mem_q[wrPtr_q] <= iDATA;
    end

    assign oDATA  = mem_q[rdPtr_q];
    assign oCOUNT = count_q;

endmodule

// File: rtl/ex_wb_arbiter.sv
// Merges divider and ALU results onto one registered writeback port.
// Optional starvation guard for buffered ALU results: EX_WB_ARB_STARVE_GUARD_EN.
module ex_wb_arbiter
    import ex_wb_arbiter_pkg::*;
(
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          iFREE_EX,
    ex_wb_arbiter_if.slave bus
);

    logic [PAYLOAD_W-1:0] fifoHead;
    logic [CNT_W-1:0]     fifoCount;
    logic                 fifoEmpty;
    logic                 fifoPush;
    logic                 fifoPop;
    logic                 divEligible;
    logic                 overflow;
    grant_e               grant;

    logic                 wbValid_q, wbValid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 errOverflow_q, errOverflow_d;
    logic                 divBusy_q, divBusy_d;

    assign fifoEmpty   = (fifoCount == '0);
    assign divEligible = bus.iDIV_VALID && !divBusy_q;

    always_comb begin
        grant = GRANT_NONE;
        if (divEligible)          grant = GRANT_DIV;
        else if (!fifoEmpty)      grant = GRANT_FIFO;
        else if (bus.iALU_VALID)  grant = GRANT_BYPASS;
    end

    assign fifoPop  = (grant == GRANT_FIFO);
    assign fifoPush = bus.iALU_VALID && (grant != GRANT_BYPASS);
    assign overflow = fifoPush && (fifoCount == FULL_COUNT) && !fifoPop;

    ex_wb_skid_fifo u_fifo (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .iFLUSH (iFREE_EX),
        .iPUSH  (fifoPush),
        .iPOP   (fifoPop),
        .iDATA  (bus.iALU_PAYLOAD),
        .oDATA  (fifoHead),
        .oCOUNT (fifoCount)
    );

    always_comb begin
        wbValid_d     = (grant != GRANT_NONE);
        payload_d     = payload_q;
        errOverflow_d = errOverflow_q || overflow;
        case (grant)
            GRANT_DIV:    payload_d = packDivPayload(bus.iDIV_COMMIT_TAG, bus.iDIV_SYSREG,
                                                     bus.iDIV_REGNAME, bus.iDIV_DATA);
            GRANT_FIFO:   payload_d = fifoHead;
            GRANT_BYPASS: payload_d = bus.iALU_PAYLOAD;
            default:      payload_d = payload_q;
        endcase
    end

`ifdef EX_WB_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_q, starve_d;

    // Only back-to-back divider wins over a waiting ALU result count; anything else restarts.
    always_comb begin
        starve_d = '0;
        if ((grant == GRANT_DIV) && !fifoEmpty)
            starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
    end

    assign divBusy_d = (starve_d == STARVE_LIMIT);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)      starve_q <= '0;
        else if (iFREE_EX) starve_q <= '0;
        else               starve_q <= starve_d;
    end
`else
    assign divBusy_d = 1'b0;
`endif

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wbValid_q     <= 1'b0;
            payload_q     <= '0;
            errOverflow_q <= 1'b0;
            divBusy_q     <= 1'b0;
        end else if (iFREE_EX) begin
            wbValid_q     <= 1'b0;
            payload_q     <= '0;
            errOverflow_q <= 1'b0;
            divBusy_q     <= 1'b0;
        end else begin
            wbValid_q     <= wbValid_d;
            payload_q     <= payload_d;
            errOverflow_q <= errOverflow_d;
            divBusy_q     <= divBusy_d;
        end
    end

    assign bus.oWB_VALID     = wbValid_q;
    assign bus.oWB_PAYLOAD   = payload_q;
    assign bus.oERR_OVERFLOW = errOverflow_q;
    assign bus.oDIV_BUSY     = divBusy_q;
    assign bus.oALU_LOCK     = (fifoCount >= LOCK_THRESH);

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Directed self-checking bench for ex_wb_arbiter (guard scenario follows EX_WB_ARB_STARVE_GUARD_EN).
module tb_ex_wb_arbiter;

    logic iCLOCK = 1'b0;
    logic inRESET;
    logic iFREE_EX;

    ex_wb_arbiter_if bus ();

    ex_wb_arbiter dut (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iFREE_EX(iFREE_EX),
        .bus     (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    int compared   = 0;
    int mismatched = 0;

    // ALU words carry non-zero flag fields so they are distinguishable from divider words.
    function automatic logic [55:0] aluWord(input logic [5:0] tag, input logic [31:0] data);
        return {tag, 1'b0, 6'd4, 1'b1, data, 5'h03, 1'b1, 4'h2};
    endfunction

    function automatic logic [55:0] divWord(input logic [5:0] tag, input logic [31:0] data);
        return {tag, 1'b0, 6'd9, 1'b1, data, 10'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWb(input string tag, input logic expValid, input logic [55:0] expPayload,
                           input logic expLock, input logic expErr, input logic expBusy);
        checkOutput({tag, ".valid"}, 64'(bus.oWB_VALID), 64'(expValid));
        if (expValid)
            checkOutput({tag, ".payload"}, 64'(bus.oWB_PAYLOAD), 64'(expPayload));
        checkOutput({tag, ".lock"}, 64'(bus.oALU_LOCK), 64'(expLock));
        checkOutput({tag, ".err"}, 64'(bus.oERR_OVERFLOW), 64'(expErr));
        checkOutput({tag, ".busy"}, 64'(bus.oDIV_BUSY), 64'(expBusy));
    endtask

    task automatic applyStimulus(input logic aluV, input logic [55:0] aluP, input logic divV,
                                 input logic [5:0] divTag, input logic [31:0] divData, input logic free);
        bus.iALU_VALID      = aluV;
        bus.iALU_PAYLOAD    = aluP;
        bus.iDIV_VALID      = divV;
        bus.iDIV_COMMIT_TAG = divTag;
        bus.iDIV_SYSREG     = 1'b0;
        bus.iDIV_REGNAME    = 6'd9;
        bus.iDIV_DATA       = divData;
        iFREE_EX            = free;
        @(posedge iCLOCK);
        #1;
    endtask

    initial begin
        inRESET  = 1'b0;
        iFREE_EX = 1'b0;
        bus.iALU_VALID      = 1'b0;
        bus.iALU_PAYLOAD    = '0;
        bus.iDIV_VALID      = 1'b0;
        bus.iDIV_COMMIT_TAG = '0;
        bus.iDIV_SYSREG     = 1'b0;
        bus.iDIV_REGNAME    = '0;
        bus.iDIV_DATA       = '0;
        repeat (3) @(posedge iCLOCK);
        #1;
        checkOutput("reset.valid", 64'(bus.oWB_VALID), 64'd0);
        checkOutput("reset.payload", 64'(bus.oWB_PAYLOAD), 64'd0);
        checkWb("reset", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);
        inRESET = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);

        // Single ALU result bypasses straight to the output register.
        applyStimulus(1'b1, aluWord(6'h05, 32'h1234), 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("bypass", 1'b1, aluWord(6'h05, 32'h1234), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("bypass.idle", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);

        // Divider wins the same-cycle collision; ALU follows from the buffer.
        applyStimulus(1'b1, aluWord(6'h03, 32'hAAAA), 1'b1, 6'h0A, 32'h7, 1'b0);
        checkWb("collide.div", 1'b1, divWord(6'h0A, 32'h7), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("collide.alu", 1'b1, aluWord(6'h03, 32'hAAAA), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("collide.idle", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);

        // Three buffered results raise the lock, then drain in order.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, aluWord(6'(6'h20 + k), 32'(k)), 1'b1, 6'h11, 32'h100, 1'b0);
            checkWb($sformatf("lock.fill%0d", k), 1'b1, divWord(6'h11, 32'h100), (k == 3), 1'b0, 1'b0);
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
            checkWb($sformatf("lock.drain%0d", k), 1'b1, aluWord(6'(6'h20 + k), 32'(k)), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("lock.idle", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);

`ifndef EX_WB_ARB_STARVE_GUARD_EN
        // Fifth result with a permanently busy writeback port is dropped.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, aluWord(6'(6'h30 + k), 32'(k)), 1'b1, 6'h12, 32'h200, 1'b0);
            checkWb($sformatf("ovf.fill%0d", k), 1'b1, divWord(6'h12, 32'h200), (k >= 3), (k == 5), 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 6'h12, 32'h200, 1'b0);
        checkWb("ovf.sticky", 1'b1, divWord(6'h12, 32'h200), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, aluWord(6'h3F, 32'h9), 1'b1, 6'h12, 32'h200, 1'b1);
        checkWb("ovf.flush", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("ovf.empty", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);
`endif

        // One buffered ALU result against a divider that never lets go.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus((k == 1), aluWord(6'h41, 32'h55), 1'b1, 6'h13, 32'h300, 1'b0);
`ifdef EX_WB_ARB_STARVE_GUARD_EN
            if (k == 6)
                checkWb("guard.fifo", 1'b1, aluWord(6'h41, 32'h55), 1'b0, 1'b0, 1'b0);
            else
                checkWb($sformatf("guard.div%0d", k), 1'b1, divWord(6'h13, 32'h300), 1'b0, 1'b0, (k == 5));
`else
            checkWb($sformatf("strict.div%0d", k), 1'b1, divWord(6'h13, 32'h300), 1'b0, 1'b0, 1'b0);
`endif
        end
`ifdef EX_WB_ARB_STARVE_GUARD_EN
        applyStimulus(1'b0, '0, 1'b1, 6'h13, 32'h300, 1'b0);
        checkWb("guard.resume", 1'b1, divWord(6'h13, 32'h300), 1'b0, 1'b0, 1'b0);
`else
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("strict.fifo", 1'b1, aluWord(6'h41, 32'h55), 1'b0, 1'b0, 1'b0);
`endif
        applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
        checkWb("guard.idle", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);

        // Reset with two results buffered loses them with no pulse afterwards.
        applyStimulus(1'b1, aluWord(6'h51, 32'h1), 1'b1, 6'h14, 32'h400, 1'b0);
        applyStimulus(1'b1, aluWord(6'h52, 32'h2), 1'b1, 6'h14, 32'h400, 1'b0);
        checkWb("rst.pre", 1'b1, divWord(6'h14, 32'h400), 1'b0, 1'b0, 1'b0);
        bus.iALU_VALID = 1'b0;
        bus.iDIV_VALID = 1'b0;
        #2 inRESET = 1'b0;
        #1;
        checkOutput("rst.async.payload", 64'(bus.oWB_PAYLOAD), 64'd0);
        checkWb("rst.async", 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);
        @(posedge iCLOCK);
        #1 inRESET = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, 1'b0);
            checkWb($sformatf("rst.after%0d", k), 1'b0, 56'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
